gray_updown_counter: RTL
========================

Name: gray_updown_counter

Overview:
- Parametrised synchronous up/down Gray-code counter, WIDTH bits, with enable, synchronous parallel load, terminal-count and wrap indication.
- Replaces the fixed 3-bit Gray up/down state machine.
- Keeps a binary count internally; drives registered Gray and binary views to the LED/display logic and to downstream clock-domain-crossing pointer logic.

Parameters:
- WIDTH, 3, counter width in bits (legal range 2..16).
- RESET_BIN, 0, binary count value loaded on reset (0 .. 2^WIDTH-1).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  count enable; one step per clk edge while high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load strobe.
- load_bin  input  WIDTH  binary value to load (not Gray).
- gray  output  WIDTH  registered Gray-code count.
- bin  output  WIDTH  registered binary count.
- tc  output  1  terminal count for the current direction (combinational from bin and up).
- wrap  output  1  one-cycle registered pulse: the last step wrapped.

Behaviour:
- One clock, synchronous active-high reset. No asynchronous paths.
- Priority at each rising clk edge: reset > load > en > hold.
- reset: bin <= RESET_BIN; gray <= RESET_BIN ^ (RESET_BIN >> 1); wrap <= 0. With the default, gray = bin = 0 and wrap = 0.
- load (reset low): bin <= load_bin; gray <= load_bin ^ (load_bin >> 1); wrap <= 0. en and up are ignored that cycle.
- en (reset and load low):
  - up = 1: bin <= bin + 1, modulo 2^WIDTH.
  - up = 0: bin <= bin - 1, modulo 2^WIDTH.
  - gray <= next_bin ^ (next_bin >> 1).
- Hold: en low with no load keeps bin and gray unchanged and forces wrap <= 0.
- Latency: the new value appears on gray/bin one cycle after the edge that samples en, load or reset.
- gray and bin come straight from flops; no combinational path from inputs to them.
- Gray sequence for WIDTH = 3, up: 000, 001, 011, 010, 110, 111, 101, 100, then 000. Down traverses it in reverse.
- Every enabled step changes exactly one bit of gray, including across wrap.
- tc = 1 when (up = 1 and bin = all-ones) or (up = 0 and bin = 0). It follows up with no delay.
- wrap <= 1 on an edge with en = 1, load = 0, reset = 0, and tc = 1 for the up value sampled there; otherwise 0.
- Direction change mid-sequence takes effect on the next enabled edge, with no skipped or repeated code.
- Reset asserted mid-count: the next edge reaches the reset state regardless of en, load and up; wrap is cleared.
- load and en both high: the load wins, no step is taken, wrap = 0.

Optional Feature:
- Macro: GRAY_COUNTER_SATURATE_EN.
- Defined:
  - The counter saturates instead of wrapping: an enabled up step at all-ones, or an enabled down step at 0, holds bin and gray.
  - wrap is then a one-cycle "saturation hit" pulse under the same conditions.
  - tc is unchanged.
- Undefined: modulo wrap-around as described in Behaviour.

Test Plan:
- WIDTH=3, reset for 2 cycles, then en=1, up=1 for 9 cycles -> gray 000, 001, 011, 010, 110, 111, 101, 100, 000. wrap=1 only in the cycle gray returns to 000. tc=1 while bin=7.
- From reset, en=1, up=0 for 3 cycles -> gray 100, 101, 111; bin 7, 6, 5. wrap=1 on the first step (0 -> 7).
- load=1, load_bin=3'b101 with en=1 and up=1 in the same cycle -> next cycle bin=101, gray=111, wrap=0. With en still 1 the following cycle -> bin=110, gray=101.
- Count to bin=2 (gray=011), then toggle up 1->0->1 with en held high -> gray 011, 001, 011. Each step changes exactly one bit.
- Assert reset while en=1 at bin=6 -> next cycle bin=0, gray=000, wrap=0. en low for 4 cycles -> values hold.
- With GRAY_COUNTER_SATURATE_EN: 10 up steps from 0 -> bin stays at 7 (gray=100) from step 7 on, with wrap=1 on each enabled step at 7. 8 down steps -> stops at gray=000.

Source files
------------

// File: rtl/gray_updown_counter.sv
// gray_updown_counter: WIDTH-bit up/down counter with registered binary and Gray views.
// Define GRAY_COUNTER_SATURATE_EN to saturate at the ends instead of wrapping.
module gray_updown_counter #(
    parameter int          WIDTH     = 3,
    parameter int unsigned RESET_BIN = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin,
    output logic             tc,
    output logic             wrap
);
    localparam logic [WIDTH-1:0] RST_BIN = WIDTH'(RESET_BIN);
    logic [WIDTH-1:0] step_bin;
    logic [WIDTH-1:0] next_bin;
    always_comb begin
        tc = up ? &bin : ~|bin;
`ifdef GRAY_COUNTER_SATURATE_EN
        step_bin = tc ? bin : (up ? bin + WIDTH'(1) : bin - WIDTH'(1));
`else
        step_bin = up ? bin + WIDTH'(1) : bin - WIDTH'(1);
`endif
        next_bin = reset ? RST_BIN : load ? load_bin : en ? step_bin : bin;
    end
    always_ff @(posedge clk) begin
        bin  <= next_bin;
        gray <= next_bin ^ (next_bin >> 1);
        wrap <= !reset && !load && en && tc;
    end
endmodule
